// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if -- buffer load, run control and instruction/status bus of
// the instruction sequencer.
//   master : drives wr_en/wr_data, start/stop/clr/loop_en, hold_cycles, ALUResult
//   slave  : drives Instr, instr_valid, idx, count, full, busy, done, sig
interface instr_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic            wr_en;
  logic [XLEN-1:0] wr_data;
  logic            start;
  logic            stop;
  logic            clr;
  logic            loop_en;
  logic [7:0]      hold_cycles;
  logic [XLEN-1:0] ALUResult;

  logic [XLEN-1:0] Instr;
  logic            instr_valid;
  logic [AW-1:0]   idx;
  logic [AW:0]     count;
  logic            full;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] sig;

  modport master (
    output wr_en, wr_data, start, stop, clr, loop_en, hold_cycles, ALUResult,
    input  Instr, instr_valid, idx, count, full, busy, done, sig
  );

  modport slave (
    input  wr_en, wr_data, start, stop, clr, loop_en, hold_cycles, ALUResult,
    output Instr, instr_valid, idx, count, full, busy, done, sig
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer -- loads up to DEPTH instruction words while IDLE, then
// replays them to a core (optionally looping), holding each word
// hold_cycles+1 cycles. Outside RUN the core sees NOP.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : instr_sequencer_if.slave (load, run control, Instr/status)
// Optional feature macro INSTR_SEQ_SIG_EN: folds ALUResult into a rotate-XOR
// signature on the last hold cycle of each word. Without it sig is tied to 0.
module instr_sequencer #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 16,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h00000013)
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   idx_q,   idx_d;
  logic [7:0]      hold_q,  hold_d;   // extra cycles still to spend on current word
  logic            mem_we;
  logic            full;
  logic            word_end;
  logic            last_word;
  logic [XLEN-1:0] mem [DEPTH];

  assign full      = (count_q == CW'(DEPTH));
  assign word_end  = (hold_q == 8'd0);
  assign last_word = ({1'b0, idx_q} == count_q - CW'(1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    mem_we  = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      count_d = '0;
      idx_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // a write always shadows a coincident start, even when it is dropped
          if (bus.wr_en) begin
            if (!full) begin
              mem_we  = 1'b1;
              count_d = count_q + CW'(1);
            end
          end else if (bus.start && count_q != '0) begin
            state_d = RUN;
            idx_d   = '0;
            hold_d  = bus.hold_cycles;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = DONE;
          end else if (word_end) begin
            if (last_word) begin
              if (bus.loop_en) begin
                idx_d  = '0;
                hold_d = bus.hold_cycles;
              end else begin
                state_d = DONE;
              end
            end else begin
              idx_d  = idx_q + AW'(1);
              hold_d = bus.hold_cycles;
            end
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        DONE: begin
          if (bus.start) begin
            state_d = RUN;
            idx_d   = '0;
            hold_d  = bus.hold_cycles;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // buffer has no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[AW-1:0]] <= bus.wr_data;
  end

`ifdef INSTR_SEQ_SIG_EN
  logic [XLEN-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (bus.clr)
      sig_d = '0;
    else if (state_q == RUN && word_end)
      sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ bus.ALUResult;
  end

  always_ff @(posedge clk) begin
    if (!reset) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign bus.sig = sig_q;
`else
  assign bus.sig = '0;
`endif

  assign bus.Instr       = (state_q == RUN) ? mem[idx_q] : NOP;
  assign bus.instr_valid = (state_q == RUN);
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.idx         = idx_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer -- directed scenarios plus randomized run control,
// checked every cycle against a word-level reference model.
module tb_instr_sequencer;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_sequencer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) ifc ();

  instr_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc.slave)
  );

  // stimulus variables
  logic        we, st, sp, cl, lp;
  logic [31:0] wd, alu;
  logic [7:0]  hc;

  assign ifc.wr_en       = we;
  assign ifc.wr_data     = wd;
  assign ifc.start       = st;
  assign ifc.stop        = sp;
  assign ifc.clr         = cl;
  assign ifc.loop_en     = lp;
  assign ifc.hold_cycles = hc;
  assign ifc.ALUResult   = alu;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: mode 0=idle 1=run 2=done; age counts cycles spent on the
  // current word, which ends once age reaches its sampled hold+1
  int          m_mode, m_cnt, m_idx, m_age, m_len;
  logic [31:0] m_buf [DEPTH];
  logic [31:0] m_sig;

  function automatic void begin_word(input int i);
    m_idx = i; m_age = 0; m_len = int'(hc) + 1;
  endfunction

  function automatic void model_step();
    bit ends;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_idx = 0; m_sig = '0;
    end else if (cl) begin
      m_mode = 0; m_cnt = 0; m_idx = 0; m_sig = '0;
    end else if (m_mode == 0) begin
      if (we) begin
        if (m_cnt < DEPTH) begin m_buf[m_cnt] = wd; m_cnt++; end
      end else if (st && m_cnt > 0) begin
        m_mode = 1; begin_word(0);
      end
    end else if (m_mode == 1) begin
      m_age++;
      ends = (m_age == m_len);
`ifdef INSTR_SEQ_SIG_EN
      if (ends) m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ alu;
`endif
      if (sp) m_mode = 2;
      else if (ends) begin
        if (m_idx + 1 < m_cnt) begin_word(m_idx + 1);
        else if (lp) begin_word(0);
        else m_mode = 2;
      end
    end else begin
      if (st) begin m_mode = 1; begin_word(0); end
    end
  endfunction

  task automatic check_outs();
    chk("Instr",       ifc.Instr,       (m_mode == 1) ? m_buf[m_idx] : NOP);
    chk("instr_valid", ifc.instr_valid, m_mode == 1);
    chk("busy",        ifc.busy,        m_mode == 1);
    chk("done",        ifc.done,        m_mode == 2);
    chk("idx",         ifc.idx,         m_idx);
    chk("count",       ifc.count,       m_cnt);
    chk("full",        ifc.full,        m_cnt == DEPTH);
    chk("sig",         ifc.sig,         m_sig);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic quiet();
    we = 0; st = 0; sp = 0; cl = 0;
  endtask

  task automatic load(input logic [31:0] w);
    we = 1; wd = w; tick(); we = 0;
  endtask

  task automatic do_clr();
    cl = 1; tick(); cl = 0;
  endtask

  int n;

  initial begin
    quiet(); lp = 0; wd = '0; hc = 0; alu = '0; rst_n = 0;
    m_mode = 0; m_cnt = 0; m_idx = 0; m_age = 0; m_len = 1; m_sig = '0;
    tick(); tick();
    chk("rst_instr", ifc.Instr, NOP);
    chk("rst_count", ifc.count, 0);
    rst_n = 1;

    // basic three-word run, one cycle per word
    load(32'h00500113); load(32'h00C00193); load(32'hFF718393);
    st = 1; tick(); st = 0;
    chk("seq0", ifc.Instr, 32'h00500113);
    tick(); chk("seq1", ifc.Instr, 32'h00C00193);
    tick(); chk("seq2", ifc.Instr, 32'hFF718393);
    tick(); chk("seq_done", ifc.done, 1'b1); chk("seq_nop", ifc.Instr, NOP);

    // re-run from DONE with hold 2: 3 cycles per word, 9 busy cycles
    hc = 2; st = 1; tick(); st = 0;
    n = 0;
    while (ifc.busy && n < 50) begin n++; tick(); end
    chk("hold_busy_cycles", n, 9);
    hc = 0;

    // overflow: DEPTH+2 writes, last two dropped
    do_clr();
    for (int i = 0; i < DEPTH + 2; i++) load(32'h1000 + i);
    chk("ovf_count", ifc.count, DEPTH);
    chk("ovf_full",  ifc.full,  1'b1);
    do_clr();
    st = 1; tick(); st = 0;
    chk("empty_start", ifc.busy, 1'b0);

    // start coincident with a write is ignored
    we = 1; wd = 32'hABCD0001; st = 1; tick(); quiet();
    chk("wr_start_busy", ifc.busy, 1'b0);
    chk("wr_start_cnt",  ifc.count, 1);

    // looping over two words, then stop
    load(32'hABCD0002);
    lp = 1; st = 1; tick(); st = 0;
    for (int i = 0; i < 4; i++) begin
      chk("loop_idx", ifc.idx, i % 2);
      tick();
    end
    sp = 1; st = 1; tick(); quiet(); lp = 0;
    chk("stop_done", ifc.done, 1'b1);

    // reset mid-run at idx 1
    do_clr();
    load(32'h11); load(32'h22); load(32'h33);
    st = 1; tick(); st = 0; tick();
    chk("pre_rst_idx", ifc.idx, 1);
    rst_n = 0; tick(); rst_n = 1;
    chk("rst_run_busy",  ifc.busy, 1'b0);
    chk("rst_run_instr", ifc.Instr, NOP);
    chk("rst_run_cnt",   ifc.count, 0);

    // signature: 5 then C
    load(32'h44); load(32'h55);
    alu = 32'h5; st = 1; tick(); st = 0;
    tick();
`ifdef INSTR_SEQ_SIG_EN
    chk("sig_first", ifc.sig, 32'h5);
`else
    chk("sig_first", ifc.sig, 32'h0);
`endif
    alu = 32'hC; tick();
`ifdef INSTR_SEQ_SIG_EN
    chk("sig_second", ifc.sig, 32'h6);
`else
    chk("sig_second", ifc.sig, 32'h0);
`endif

    // randomized control traffic
    for (int c = 0; c < 1500; c++) begin
      we    = ($urandom_range(99) < 35);
      wd    = $urandom;
      st    = ($urandom_range(99) < 12);
      sp    = ($urandom_range(99) < 3);
      cl    = ($urandom_range(99) < 2);
      lp    = ($urandom_range(99) < 40);
      hc    = 8'($urandom_range(3));
      alu   = $urandom;
      rst_n = ($urandom_range(199) != 0);
      tick();
    end
    quiet(); rst_n = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction/data word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning instruction buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter NOP, default 32'h00000013, meaning word driven on Instr when not running.
REQ-004 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports: wr_en  input  1 and wr_data  input  XLEN, which append one word to the buffer.
REQ-007 SHALL have ports: start, stop, clr, loop_en  input  1 each, which are run control.
REQ-008 SHALL have port: hold_cycles  input  8  extra cycles each instruction is held.
REQ-009 SHALL have port: ALUResult  input  XLEN  core result sampled for signature.
REQ-010 SHALL have port: Instr  output  XLEN  instruction presented to core.
REQ-011 SHALL have port: instr_valid  output  1  Instr holds a buffered word.
REQ-012 SHALL have port: idx  output  $clog2(DEPTH)  index of current instruction.
REQ-013 SHALL have ports: count  output  $clog2(DEPTH)+1  words loaded; full  output  1.
REQ-014 SHALL have ports: busy, done  output  1 each, and sig  output  XLEN  result signature.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 In IDLE, wr_en with count<DEPTH SHALL write wr_data at address count and increment count next cycle.
REQ-017 wr_en when full=1 (count==DEPTH) or outside IDLE SHALL be ignored with no state change.
REQ-018 start in IDLE with count>0 and wr_en=0 SHALL enter RUN; Instr=buffer[0], idx=0, instr_valid=1 on the next cycle (1-cycle latency).
REQ-019 start with count==0, or coincident with wr_en, SHALL be ignored (write wins).
REQ-020 In RUN, each word SHALL be held hold_cycles+1 cycles (hold_cycles=0 -> one cycle per word); hold_cycles SHALL be sampled at the start of each word.
REQ-021 After the last cycle of word count-1: if loop_en=1 then idx wraps to 0 and RUN continues, else the FSM enters DONE.
REQ-022 In DONE, done=1, busy=0, instr_valid=0, Instr=NOP; DONE SHALL persist until start (re-run from idx 0, buffer kept) or clr.
REQ-023 busy SHALL be 1 exactly while in RUN.
REQ-024 stop in RUN SHALL enter DONE next cycle regardless of loop_en or hold count.
REQ-025 clr SHALL take priority over all inputs: next cycle IDLE, count=0, sig=0, done=0; buffer contents need not be cleared.
REQ-026 Simultaneous start and stop in RUN: stop wins.
REQ-027 Outside RUN, Instr SHALL equal NOP.

Reset
REQ-028 With reset=0 at a clk edge, SHALL force IDLE, count=0, idx=0, Instr=NOP, instr_valid=0, busy=0, done=0, full=0, sig=0.
REQ-029 Reset mid-RUN SHALL abort immediately with the REQ-028 values; buffer contents are don't-care.

Configuration
REQ-030 Macro INSTR_SEQ_SIG_EN defined: on the last hold cycle of each word in RUN, sig SHALL update to {sig[XLEN-2:0],sig[XLEN-1]} XOR ALUResult.
REQ-031 INSTR_SEQ_SIG_EN undefined: sig SHALL be constant 0 and no signature register SHALL be synthesised.

Verification
REQ-032 Load 00500113, 00C00193, FF718393; start, hold=0, loop=0 -> Instr sequence 00500113, 00C00193, FF718393 on 3 consecutive cycles, then done=1, Instr=00000013.
REQ-033 Same load, hold_cycles=2 -> each word present exactly 3 cycles; busy high 9 cycles.
REQ-034 Load DEPTH+2 words -> count=DEPTH, full=1, last 2 writes dropped; start with count==0 after clr -> stays IDLE.
REQ-035 loop_en=1, 2 words, hold=0 -> idx 0,1,0,1...; assert stop -> DONE next cycle.
REQ-036 reset=0 asserted during RUN at idx=1 -> next cycle all outputs at REQ-028 values.
REQ-037 INSTR_SEQ_SIG_EN defined, ALUResult=00000005 then 0000000C, hold=0 -> sig=00000005 then 00000006; undefined -> sig stays 0.
